// File: rtl/car_pkg.sv
// car_pkg: shared direction encoding, sprite size and FSM state encoding (erase states only with CAR_ERASE_EN)
package car_pkg;
  localparam int SPRITE_SIZE = 15;
  localparam logic [2:0] DIR_E  = 3'd0;
  localparam logic [2:0] DIR_NE = 3'd1;
  localparam logic [2:0] DIR_N  = 3'd2;
  localparam logic [2:0] DIR_NW = 3'd3;
  localparam logic [2:0] DIR_W  = 3'd4;
  localparam logic [2:0] DIR_SW = 3'd5;
  localparam logic [2:0] DIR_S  = 3'd6;
  localparam logic [2:0] DIR_SE = 3'd7;
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
`ifdef CAR_ERASE_EN
    ERASE_REQ  = 3'd1,
    ERASE_WAIT = 3'd2,
`endif
    UPDATE     = 3'd3,
    DRAW_REQ   = 3'd4,
    DRAW_WAIT  = 3'd5
  } state_t;
  function automatic logic [2:0] dir_turn(input logic [2:0] d, input logic l, input logic r);
    return (l && !r) ? d + 3'd1 : (r && !l) ? d - 3'd1 : d;
  endfunction
endpackage

// File: rtl/car_step.sv
// car_step: combinational one-pixel step along a heading, each axis clamped independently
module car_step
  import car_pkg::*;
#(
  parameter logic [7:0] X_MAX = 8'd145,
  parameter logic [6:0] Y_MAX = 7'd105
) (
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] dir,
  input  logic       go,
  output logic [7:0] nx,
  output logic [6:0] ny
);
  logic xp, xn, yp, yn;
  always_comb begin
    xp = go && (dir == DIR_E || dir == DIR_NE || dir == DIR_SE);
    xn = go && (dir == DIR_W || dir == DIR_NW || dir == DIR_SW);
    yn = go && (dir == DIR_N || dir == DIR_NE || dir == DIR_NW);
    yp = go && (dir == DIR_S || dir == DIR_SE || dir == DIR_SW);
    nx = (xp && x < X_MAX) ? x + 8'd1 : (xn && x != 8'd0) ? x - 8'd1 : x;
    ny = (yp && y < Y_MAX) ? y + 7'd1 : (yn && y != 7'd0) ? y - 7'd1 : y;
  end
endmodule

// File: rtl/car_motion_ctrl.sv
// car_motion_ctrl: per-frame erase/update/draw sequencer for the car sprite
// CAR_ERASE_EN adds the background-colour erase pass before each update.
module car_motion_ctrl
  import car_pkg::*;
#(
  parameter int X_SCREEN_PIXELS = 160,
  parameter int Y_SCREEN_PIXELS = 120,
  parameter int X_START = 80,
  parameter int Y_START = 60
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iTick,
  input  logic       iTurnL,
  input  logic       iTurnR,
  input  logic       iGo,
  input  logic       iDrawDone,
  output logic [7:0] oX,
  output logic [6:0] oY,
  output logic [2:0] oDir,
  output logic       oDrawCar,
  output logic       oErase,
  output logic       oBusy,
  output logic       oOverrun
);
  state_t state;
  logic pend_l, pend_r, turn_l, turn_r;
  logic [2:0] ndir;
  logic [7:0] nx;
  logic [6:0] ny;
  assign turn_l = pend_l | iTurnL;
  assign turn_r = pend_r | iTurnR;
  assign ndir = dir_turn(oDir, turn_l, turn_r);
  car_step #(
    .X_MAX(8'(X_SCREEN_PIXELS - SPRITE_SIZE)),
    .Y_MAX(7'(Y_SCREEN_PIXELS - SPRITE_SIZE))
  ) u_step (
    .x(oX),
    .y(oY),
    .dir(ndir),
    .go(iGo),
    .nx(nx),
    .ny(ny)
  );
`ifndef CAR_ERASE_EN
  assign oErase = 1'b0;
`endif
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state <= IDLE;
      oX <= 8'(X_START);
      oY <= 7'(Y_START);
      oDir <= DIR_E;
      pend_l <= 1'b0;
      pend_r <= 1'b0;
      oDrawCar <= 1'b0;
`ifdef CAR_ERASE_EN
      oErase <= 1'b0;
`endif
      oBusy <= 1'b0;
      oOverrun <= 1'b0;
    end else begin
      oOverrun <= iTick && state != IDLE;
      pend_l <= (state == UPDATE) ? 1'b0 : turn_l;
      pend_r <= (state == UPDATE) ? 1'b0 : turn_r;
      case (state)
        IDLE: if (iTick) begin
`ifdef CAR_ERASE_EN
          state <= ERASE_REQ;
          oDrawCar <= 1'b1;
          oErase <= 1'b1;
`else
          state <= UPDATE;
`endif
          oBusy <= 1'b1;
        end
`ifdef CAR_ERASE_EN
        ERASE_REQ: begin
          state <= ERASE_WAIT;
          oDrawCar <= 1'b0;
        end
        ERASE_WAIT: if (iDrawDone) begin
          state <= UPDATE;
          oErase <= 1'b0;
        end
`endif
        UPDATE: begin
          oX <= nx;
          oY <= ny;
          oDir <= ndir;
          state <= DRAW_REQ;
          oDrawCar <= 1'b1;
        end
        DRAW_REQ: begin
          state <= DRAW_WAIT;
          oDrawCar <= 1'b0;
        end
        DRAW_WAIT: if (iDrawDone) begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_car_motion_ctrl.sv
// tb_car_motion_ctrl: directed frame sequences with hand-computed positions, clamp, turn wrap, overrun and reset
module tb_car_motion_ctrl;
  logic clk = 1'b0;
  logic iReset = 1'b1, iTick = 1'b0, iTurnL = 1'b0, iTurnR = 1'b0, iGo = 1'b0, iDrawDone = 1'b0;
  logic [7:0] oX;
  logic [6:0] oY;
  logic [2:0] oDir;
  logic oDrawCar, oErase, oBusy, oOverrun;
  int vectors = 0, miscompares = 0;
  logic [7:0] cx = 8'd80;
  logic [6:0] cy = 7'd60;
  logic [2:0] cd = 3'd0;
  always #5 clk = ~clk;
  car_motion_ctrl dut (
    .iClock(clk),
    .iReset(iReset),
    .iTick(iTick),
    .iTurnL(iTurnL),
    .iTurnR(iTurnR),
    .iGo(iGo),
    .iDrawDone(iDrawDone),
    .oX(oX),
    .oY(oY),
    .oDir(oDir),
    .oDrawCar(oDrawCar),
    .oErase(oErase),
    .oBusy(oBusy),
    .oOverrun(oOverrun)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wait_req(input string tag);
    int n = 0;
    while (!oDrawCar && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, 32'(oDrawCar), 32'd1);
  endtask
  task automatic done();
    repeat (3) @(negedge clk);
    iDrawDone = 1'b1;
    @(negedge clk);
    iDrawDone = 1'b0;
  endtask
  task automatic pulse_turn(input logic l, input logic r);
    iTurnL = l;
    iTurnR = r;
    @(negedge clk);
    iTurnL = 1'b0;
    iTurnR = 1'b0;
  endtask
  task automatic frame(input string tag, input logic [7:0] ex, input logic [6:0] ey, input logic [2:0] ed);
    iTick = 1'b1;
    @(negedge clk);
    iTick = 1'b0;
`ifdef CAR_ERASE_EN
    wait_req({tag, "_erase"});
    check({tag, "_erase_flag"}, 32'(oErase), 32'd1);
    check({tag, "_erase_xy"}, {17'd0, oX, oY}, {17'd0, cx, cy});
    done();
`endif
    wait_req(tag);
    check({tag, "_draw_erase"}, 32'(oErase), 32'd0);
    check({tag, "_x"}, 32'(oX), 32'(ex));
    check({tag, "_y"}, 32'(oY), 32'(ey));
    check({tag, "_dir"}, 32'(oDir), 32'(ed));
    done();
    check({tag, "_idle"}, 32'(oBusy), 32'd0);
    cx = ex;
    cy = ey;
    cd = ed;
  endtask
  initial begin
    int draws;
    repeat (3) @(negedge clk);
    check("rst_x", 32'(oX), 32'd80);
    check("rst_y", 32'(oY), 32'd60);
    check("rst_dir", 32'(oDir), 32'd0);
    check("rst_outs", {28'd0, oDrawCar, oErase, oBusy, oOverrun}, 32'd0);
    iReset = 1'b0;
    draws = 0;
    repeat (5) begin
      @(negedge clk);
      if (oDrawCar) draws++;
    end
    check("no_draw_before_tick", 32'(draws), 32'd0);
    frame("still", 8'd80, 7'd60, 3'd0);
    iGo = 1'b1;
    pulse_turn(1'b1, 1'b0);
    frame("ne", 8'd81, 7'd59, 3'd1);
    pulse_turn(1'b0, 1'b1);
    for (int k = 1; k <= 66; k++)
      frame("east", (81 + k > 145) ? 8'd145 : 8'(81 + k), 7'd59, 3'd0);
    pulse_turn(1'b0, 1'b1);
    frame("se_clamp", 8'd145, 7'd60, 3'd7);
    frame("se_clamp2", 8'd145, 7'd61, 3'd7);
    iGo = 1'b0;
    pulse_turn(1'b1, 1'b1);
    frame("both_turn", 8'd145, 7'd61, 3'd7);
    pulse_turn(1'b1, 1'b0);
    frame("wrap_7_0", 8'd145, 7'd61, 3'd0);
    pulse_turn(1'b0, 1'b1);
    frame("wrap_0_7", 8'd145, 7'd61, 3'd7);
    iTick = 1'b1;
    @(negedge clk);
    iTick = 1'b0;
`ifdef CAR_ERASE_EN
    wait_req("ovr_erase");
    done();
`endif
    wait_req("ovr");
    @(negedge clk);
    iTick = 1'b1;
    @(negedge clk);
    iTick = 1'b0;
    check("ovr_pulse", 32'(oOverrun), 32'd1);
    @(negedge clk);
    check("ovr_single", 32'(oOverrun), 32'd0);
    iDrawDone = 1'b1;
    @(negedge clk);
    iDrawDone = 1'b0;
    draws = 0;
    repeat (10) begin
      @(negedge clk);
      if (oDrawCar) draws++;
    end
    check("ovr_no_extra_draw", 32'(draws), 32'd0);
    check("ovr_idle", 32'(oBusy), 32'd0);
    iTick = 1'b1;
    @(negedge clk);
    iTick = 1'b0;
    wait_req("mid_rst");
    @(negedge clk);
    pulse_turn(1'b1, 1'b0);
    iReset = 1'b1;
    @(negedge clk);
    iReset = 1'b0;
    check("mid_rst_busy", 32'(oBusy), 32'd0);
    check("mid_rst_draw", 32'(oDrawCar), 32'd0);
    check("mid_rst_erase", 32'(oErase), 32'd0);
    check("mid_rst_xy", {17'd0, oX, oY}, {17'd0, 8'd80, 7'd60});
    check("mid_rst_dir", 32'(oDir), 32'd0);
    iDrawDone = 1'b1;
    @(negedge clk);
    iDrawDone = 1'b0;
    draws = 0;
    repeat (10) begin
      @(negedge clk);
      if (oDrawCar || oBusy) draws++;
    end
    check("late_done_ignored", 32'(draws), 32'd0);
    cx = 8'd80;
    cy = 7'd60;
    frame("post_rst", 8'd80, 7'd60, 3'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/car_motion_ctrl.md
CAR_MOTION_CTRL -- requirements
Module: car_motion_ctrl

Interface
REQ-001 SHALL have parameter X_SCREEN_PIXELS, default 160, screen width in pixels.
REQ-002 SHALL have parameter Y_SCREEN_PIXELS, default 120, screen height in pixels.
REQ-003 SHALL have parameter X_START, default 80, car x after reset.
REQ-004 SHALL have parameter Y_START, default 60, car y after reset.
REQ-005 SHALL have port iClock, input, 1 bit, the single clock; reset is synchronous and active-high.
REQ-006 SHALL have port iReset, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port iTick, input, 1 bit, one-cycle frame-rate pulse.
REQ-008 SHALL have port iTurnL, input, 1 bit, rotate-left request pulse.
REQ-009 SHALL have port iTurnR, input, 1 bit, rotate-right request pulse.
REQ-010 SHALL have port iGo, input, 1 bit, level; move while high.
REQ-011 SHALL have port iDrawDone, input, 1 bit, done pulse from the downstream car drawer.
REQ-012 SHALL have port oX, output, 8 bits, sprite upper-left x.
REQ-013 SHALL have port oY, output, 7 bits, sprite upper-left y.
REQ-014 SHALL have port oDir, output, 3 bits, heading: 0 E, 1 NE, 2 N, 3 NW, 4 W, 5 SW, 6 S, 7 SE.
REQ-015 SHALL have port oDrawCar, output, 1 bit, one-cycle draw request to the drawer.
REQ-016 SHALL have port oErase, output, 1 bit, high during an erase request/wait (background colour draw).
REQ-017 SHALL have port oBusy, output, 1 bit, high in any state other than IDLE.
REQ-018 SHALL have port oOverrun, output, 1 bit, one-cycle pulse when iTick arrives while busy.

Function
REQ-019 FSM states SHALL be IDLE, ERASE_REQ, ERASE_WAIT, UPDATE, DRAW_REQ, DRAW_WAIT.
REQ-020 IDLE with iTick SHALL go to ERASE_REQ; iTick absent SHALL stay IDLE.
REQ-021 ERASE_REQ SHALL assert oDrawCar and oErase for exactly one cycle with the old oX/oY/oDir, then go to ERASE_WAIT.
REQ-022 ERASE_WAIT SHALL hold oErase high until iDrawDone, then go to UPDATE next cycle.
REQ-023 UPDATE (one cycle) SHALL apply pending turn, then move one pixel along the new heading if iGo is high; N decreases y, E increases x.
REQ-024 Turn: left SHALL be dir+1 mod 8, right SHALL be dir-1 mod 8 (7->0, 0->7 wrap).
REQ-025 Turn pulses SHALL latch into pending flags in any state and clear in UPDATE; both flags set SHALL leave dir unchanged.
REQ-026 Each axis SHALL clamp independently: x in 0..X_SCREEN_PIXELS-15, y in 0..Y_SCREEN_PIXELS-15; a step leaving range SHALL hold that axis only.
REQ-027 DRAW_REQ SHALL assert oDrawCar one cycle with new position, oErase low, then DRAW_WAIT.
REQ-028 DRAW_WAIT SHALL return to IDLE on iDrawDone.
REQ-029 iDrawDone outside the *_WAIT states SHALL be ignored.
REQ-030 iTick while oBusy SHALL be dropped and SHALL pulse oOverrun the following cycle.
REQ-031 oX/oY/oDir SHALL change only in UPDATE and stay stable during every request/wait state.

Reset
REQ-032 iReset SHALL, at any state including mid-handshake, force IDLE, oX=X_START, oY=Y_START, oDir=0, clear pending flags, and drive oDrawCar, oErase, oBusy and oOverrun to 0.
REQ-033 On the first cycle after reset, the block SHALL issue no draw request until iTick.

Configuration
REQ-034 Macro CAR_ERASE_EN SHALL control the erase pass.
REQ-035 When CAR_ERASE_EN is defined, the FSM SHALL follow REQ-020..022.
REQ-036 When CAR_ERASE_EN is undefined, IDLE+iTick SHALL go directly to UPDATE, ERASE states SHALL be absent, and oErase SHALL be tied 0.

Structure
REQ-037 Shared package car_pkg SHALL hold the direction encoding constants, sprite bounding size 15, and FSM state encoding.
REQ-038 Sub-module car_step SHALL be combinational: (x, y, dir, go) -> clamped next (x, y).

Verification
REQ-039 Reset, then iTick with iGo=0 and iDrawDone returned 3 cycles after each request -> erase at (80,60), draw at (80,60), dir 0, back to IDLE.
REQ-040 iGo=1, dir 1, at (80,60), one tick -> draw request at (81,59).
REQ-041 Car at x=145, dir 0, iGo=1, tick -> x stays 145; dir 7 at (145,60) -> (145,61).
REQ-042 Dir 0 with iTurnR pulse, then tick -> oDir=7; iTurnL and iTurnR both pulsed, then tick -> dir unchanged.
REQ-043 iTick during DRAW_WAIT -> oOverrun pulses once and no extra draw occurs.
REQ-044 iReset asserted in ERASE_WAIT -> next cycle IDLE, oDrawCar=0, position (80,60); late iDrawDone ignored.
